fp32_uart_tx_96: RTL and testbench
==================================

FP32_UART_TX_96 -- requirements
Module: fp32_uart_tx_96

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208; clock cycles per UART bit (minimum 2).
REQ-002 SHALL have port CLK_I  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port RST_I  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port TX_VALID_I  input  1  a 96-bit word is offered on TX_DATA_I.
REQ-005 SHALL have port TX_DATA_I  input  96  word to send (three packed fp32 values).
REQ-006 SHALL have port TX_READY_O  output  1  block can accept a word this cycle.
REQ-007 SHALL have port UART_TX_O  output  1  serial line; idle high.
REQ-008 SHALL have port TX_ACTIVE_O  output  1  a word is being shifted out.
REQ-009 SHALL have port TX_DONE_O  output  1  one-cycle pulse when the last stop bit completes.

Function
REQ-010 SHALL accept a word on a rising edge where TX_VALID_I=1 and TX_READY_O=1, and SHALL register TX_DATA_I internally at that edge.
REQ-011 SHALL ignore TX_DATA_I and TX_VALID_I at all other times; input changes after acceptance have no effect on the transmitted word.
REQ-012 SHALL drive TX_READY_O=1 only in state IDLE; it is registered state, not combinationally dependent on TX_VALID_I.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, DONE.
REQ-014 IDLE: UART_TX_O=1, TX_ACTIVE_O=0; on accept -> START, byte index=0, bit index=0, clock counter=0.
REQ-015 START: UART_TX_O=0 for exactly CLKS_PER_BIT cycles, then -> DATA.
REQ-016 DATA: UART_TX_O = bit[bit index] of current byte for exactly CLKS_PER_BIT cycles per bit, LSB first; after bit 7 -> STOP.
REQ-017 STOP: UART_TX_O=1 for exactly CLKS_PER_BIT cycles; then if byte index<11 -> START with byte index+1, else -> DONE.
REQ-018 Byte order SHALL be least-significant first: byte k = TX_DATA[8k+7:8k], k=0..11.
REQ-019 DONE: lasts one cycle, UART_TX_O=1, TX_DONE_O=1, TX_READY_O=0; then -> IDLE.
REQ-020 TX_ACTIVE_O SHALL be 1 in START, DATA, STOP; 0 in IDLE and DONE.
REQ-021 UART_TX_O SHALL first go low in the cycle after the accepting edge; one word occupies exactly 120*CLKS_PER_BIT cycles from that point to DONE.
REQ-022 Bytes SHALL be back-to-back: no idle cycles between a stop bit and the next start bit.
REQ-023 Minimum spacing between accepts SHALL be 120*CLKS_PER_BIT+2 cycles (line time + DONE + IDLE).
REQ-024 UART_TX_O, TX_ACTIVE_O, TX_DONE_O, TX_READY_O SHALL be driven from registers (glitch-free line).
REQ-025 Clock counter SHALL be wide enough for CLKS_PER_BIT-1 ($clog2 width); byte index 4 bits, bit index 3 bits; no wrap beyond defined ranges.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next edge with UART_TX_O=1.

Reset
REQ-027 While RST_I=1 at a rising edge: state=IDLE, UART_TX_O=1, TX_READY_O=1 from the following cycle, TX_ACTIVE_O=0, TX_DONE_O=0, counters=0.
REQ-028 Reset mid-word SHALL abort the frame immediately (line returns high next cycle), SHALL NOT pulse TX_DONE_O, and SHALL discard the latched word.
REQ-029 A TX_VALID_I asserted during the reset edge SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 Send 96'h0000_0000_0000_0000_0000_00A5: bench UART decoder SHALL read bytes A5,00x11 with valid start/stop bits; TX_DONE_O pulses once, exactly 480 cycles after first start-bit cycle.
REQ-031 Send 96'h3F80_0000_4000_0000_C0A0_0000 (1.0, 2.0, -5.0): decoded bytes SHALL be 00,00,A0,C0,00,00,00,40,00,00,80,3F.
REQ-032 Hold TX_VALID_I=1 continuously with changing TX_DATA_I: each word accepted only when TX_READY_O=1; successive accepts exactly 482 cycles apart; line content matches data at each accept edge.
REQ-033 Assert RST_I during byte 5 data bit 3: UART_TX_O=1 next cycle, no TX_DONE_O, TX_READY_O=1; a subsequent word transmits correctly.
REQ-034 CLKS_PER_BIT=5208: every bit period measured on UART_TX_O SHALL be exactly 5208 cycles; TX_ACTIVE_O high for 624960 cycles.

Source files
------------

// File: rtl/fp32_uart_tx_96.sv
// ---------------------------------------------------------------------------
// fp32_uart_tx_96
//   Serialises one 96-bit word (three packed fp32 values) as twelve 8N1 UART
//   frames, least-significant byte first, LSB first within each byte.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   CLK_I        in   clock, all logic on the rising edge
//   RST_I        in   synchronous active-high reset
//   TX_VALID_I   in   a word is offered on TX_DATA_I
//   TX_DATA_I    in   [95:0] word to send
//   TX_READY_O   out  high only in IDLE; a word is accepted when VALID&READY
//   UART_TX_O    out  serial line, idle high
//   TX_ACTIVE_O  out  high while START/DATA/STOP bits are on the line
//   TX_DONE_O    out  one-cycle pulse after the final stop bit
// ---------------------------------------------------------------------------
module fp32_uart_tx_96 #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        TX_VALID_I,
   input  logic [95:0] TX_DATA_I,
   output logic        TX_READY_O,
   output logic        UART_TX_O,
   output logic        TX_ACTIVE_O,
   output logic        TX_DONE_O
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_BYTE = 4'd11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [3:0]       byte_q,  byte_d;
   logic [2:0]       bit_q,   bit_d;
   logic [95:0]      data_q,  data_d;
   logic             uart_q,  uart_d;
   logic             ready_q, ready_d;
   logic             active_q, active_d;
   logic             done_q,  done_d;

   logic             cnt_end;
   assign cnt_end = (cnt_q == CNT_MAX);

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      bit_d   = bit_q;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (TX_VALID_I && ready_q) begin
               data_d  = TX_DATA_I;
               state_d = START;
               cnt_d   = '0;
               byte_d  = '0;
               bit_d   = '0;
            end
         end

         START: begin
            if (cnt_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt_end) begin
               cnt_d = '0;
               if (byte_q < LAST_BYTE) begin
                  byte_d  = byte_q + 4'd1;
                  bit_d   = '0;
                  state_d = START;
               end else begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
            byte_d  = '0;
            bit_d   = '0;
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            byte_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the *next* state and registered, so the line
   // changes on the same edge as the state and never glitches.
   always_comb begin
      uart_d   = 1'b1;
      ready_d  = 1'b0;
      active_d = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         IDLE:  ready_d = 1'b1;
         START: begin
            uart_d   = 1'b0;
            active_d = 1'b1;
         end
         DATA: begin
            uart_d   = data_d[{byte_d, bit_d}];
            active_d = 1'b1;
         end
         STOP:  active_d = 1'b1;
         DONE:  done_d   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         byte_q   <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         uart_q   <= 1'b1;
         ready_q  <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         uart_q   <= uart_d;
         ready_q  <= ready_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign UART_TX_O   = uart_q;
   assign TX_READY_O  = ready_q;
   assign TX_ACTIVE_O = active_q;
   assign TX_DONE_O   = done_q;

endmodule

// File: tb/tb_fp32_uart_tx_96.sv
// ---------------------------------------------------------------------------
// tb_fp32_uart_tx_96
//   Directed bench for fp32_uart_tx_96 with CLKS_PER_BIT=4. Inputs are driven
//   on the falling edge and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fp32_uart_tx_96;

   localparam int C     = 4;
   localparam int FRAME = 120 * C;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [95:0] data;
   logic        ready, line, active, done;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int acc_cyc[$];

   always #5 clk = ~clk;

   fp32_uart_tx_96 #(.CLKS_PER_BIT(C)) dut (
      .CLK_I       (clk),
      .RST_I       (rst),
      .TX_VALID_I  (valid),
      .TX_DATA_I   (data),
      .TX_READY_O  (ready),
      .UART_TX_O   (line),
      .TX_ACTIVE_O (active),
      .TX_DONE_O   (done)
   );

   // Logs the cycle number of every accepting edge.
   always @(posedge clk) begin
      if (!rst && valid && ready) acc_cyc.push_back(cyc);
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called right after the accepting edge. Walks the whole frame cycle by
   // cycle, decodes each byte at mid-bit, then checks DONE and IDLE.
   // At frame cycle 3 the inputs are changed to nxt_data / nxt_valid.
   task automatic run_frame(input string tag, input logic [95:0] w,
                            input logic [95:0] nxt_data, input logic nxt_valid);
      int line_err = 0, act_err = 0, misc_err = 0;
      int k, pos;
      logic exp_line;
      logic [7:0] b;
      logic st, sp;
      b = '0; st = 1'b1; sp = 1'b0;
      for (int n = 0; n < FRAME; n++) begin
         @(negedge clk);
         k   = n / (10 * C);
         pos = (n % (10 * C)) / C;
         exp_line = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : w[8*k + pos - 1];
         if (line !== exp_line) line_err++;
         if (active !== 1'b1) act_err++;
         if (done !== 1'b0 || ready !== 1'b0) misc_err++;
         if ((n % C) == C / 2) begin
            if (pos == 0) st = line;
            else if (pos == 9) begin
               sp = line;
               check($sformatf("%s_b%0d_start", tag, k), {95'd0, st}, 96'd0);
               check($sformatf("%s_b%0d_stop", tag, k), {95'd0, sp}, 96'd1);
               check($sformatf("%s_b%0d_byte", tag, k), {88'd0, b}, {88'd0, w[8*k +: 8]});
            end else b[pos-1] = line;
         end
         if (n == 3) begin
            data  = nxt_data;
            valid = nxt_valid;
         end
      end
      check({tag, "_line_exact"}, line_err, 0);
      check({tag, "_active_frame"}, act_err, 0);
      check({tag, "_done_ready_frame"}, misc_err, 0);
      @(negedge clk);   // DONE cycle: 480 cycles after first start-bit cycle
      check({tag, "_done_pulse"}, {92'd0, done, ready, active, line}, {92'd0, 4'b1001});
      @(negedge clk);   // IDLE cycle
      check({tag, "_idle"}, {92'd0, done, ready, active, line}, {92'd0, 4'b0101});
   endtask

   localparam logic [95:0] W1 = 96'h0000_0000_0000_0000_0000_00A5;
   localparam logic [95:0] W2 = 96'h3F80_0000_4000_0000_C0A0_0000;
   localparam logic [95:0] W3 = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
   localparam logic [95:0] W4 = 96'hFFFF_0000_AAAA_5555_8001_7FFE;
   localparam logic [95:0] W5 = 96'hC3C3_3C3C_0102_0408_1020_4080;
   localparam logic [95:0] W6 = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [95:0] W7 = 96'hDEAD_BEEF_CAFE_F00D_4049_0FDB;

   initial begin
      logic [7:0]  exp_b2 [12];
      logic [95:0] w2v;
      int done_err;
      exp_b2 = '{8'h00, 8'h00, 8'hA0, 8'hC0, 8'h00, 8'h00,
                 8'h00, 8'h40, 8'h00, 8'h00, 8'h80, 8'h3F};

      rst = 1'b1; valid = 1'b0; data = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {92'd0, done, ready, active, line}, {92'd0, 4'b0101});

      // VALID during a reset edge must not start a frame.
      valid = 1'b1; data = W6;
      @(negedge clk);
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      check("valid_in_reset_ignored", {94'd0, ready, line}, {94'd0, 2'b11});

      // Byte table for the 1.0/2.0/-5.0 word, written out by hand.
      w2v = W2;
      for (int k = 0; k < 12; k++)
         check($sformatf("w2_byte_order_%0d", k), {88'd0, w2v[8*k +: 8]}, {88'd0, exp_b2[k]});

      // Single word A5, data scrambled after acceptance.
      data = W1; valid = 1'b1;
      @(posedge clk);
      run_frame("w1", W1, ~W1, 1'b0);

      data = W2; valid = 1'b1;
      @(posedge clk);
      run_frame("w2", W2, '0, 1'b0);

      // VALID held high, data changing while busy.
      data = W3; valid = 1'b1;
      @(posedge clk);
      run_frame("w3", W3, W4, 1'b1);
      @(posedge clk);
      run_frame("w4", W4, W5, 1'b1);
      @(posedge clk);
      run_frame("w5", W5, '0, 1'b0);
      check("accept_count", acc_cyc.size(), 5);
      if (acc_cyc.size() == 5) begin
         check("spacing_34", acc_cyc[3] - acc_cyc[2], FRAME + 2);
         check("spacing_45", acc_cyc[4] - acc_cyc[3], FRAME + 2);
      end

      // Reset during byte 5, data bit 3.
      data = W6 ^ 96'h0000_0000_0000_0800_0000_0000; valid = 1'b1;
      w2v = data;
      @(posedge clk);
      for (int n = 0; n <= 5*10*C + 4*C + 1; n++) begin
         @(negedge clk);
         if (n == 0) valid = 1'b0;
      end
      check("pre_reset_bit", {95'd0, line}, {95'd0, w2v[8*5 + 3]});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", {92'd0, done, ready, active, line}, {92'd0, 4'b0101});
      done_err = 0;
      for (int n = 0; n < 2 * FRAME; n++) begin
         @(negedge clk);
         if (done !== 1'b0 || line !== 1'b1) done_err++;
      end
      check("no_done_after_abort", done_err, 0);

      data = W7; valid = 1'b1;
      @(posedge clk);
      run_frame("w7", W7, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
